cache_fill_ctrl: RTL and testbench

Miss controller and memory arbiter for the split 2-way set-associative I-cache and D-cache (64 sets, 16-byte blocks). It grants the single shared main-memory read port to one missing cache at a time and issues the eight word reads of the block. It steers returning words into the granted cache's data array, then pulses that cache's tag/LRU write for one cycle. Sits between both cache wrappers and the pipelined main memory.

---
 rtl/cache_fill_ctrl.sv | 156 +++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss controller and shared main-memory arbiter for the
// split I/D caches. It grants the memory read port to one missing cache,
// issues the eight word reads of its 16-byte block, steers the returning
// words into that cache's data array and then pulses its tag/LRU write.
module cache_fill_ctrl #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              mem_data_valid,
    input  logic [15:0]       mem_data_in,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [2:0]        fill_word,
    output logic [15:0]       fill_data,
    output logic              fill_we_i,
    output logic              fill_we_d,
    output logic              tag_we_i,
    output logic              tag_we_d,
    output logic              busy
);

    // The controller reacts only to mem_data_valid, so MEM_LATENCY only has
    // to be sane; ADDR_W must hold the 4-bit block offset plus a tag bit.
    if (MEM_LATENCY < 1 || ADDR_W < 5) begin : g_param_check
        $error("cache_fill_ctrl: MEM_LATENCY must be >= 1 and ADDR_W >= 5");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(15);

    state_t            state_q, state_d;
    logic [3:0]        iss_q;          // reads issued, 0..8
    logic [2:0]        rcv_q;          // words received, 0..7
    logic              last_grant_d_q; // 0: I served last, 1: D served last
    logic              grant_d_q;      // cache owning the current fill
    logic [ADDR_W-1:0] fill_addr_q;

    logic              grant;
    logic              grant_sel_d;
    logic [ADDR_W-1:0] grant_base;
    logic              issuing;
    logic              receiving;

    // Arbitration: a lone miss wins; on a tie the side not served last wins.
    always_comb begin
        grant       = (state_q == IDLE) && (i_miss || d_miss);
        grant_sel_d = d_miss && (!i_miss || !last_grant_d_q);
        grant_base  = (grant_sel_d ? d_miss_addr : i_miss_addr) & BLOCK_MASK;
    end

    // Next-state logic and all datapath outputs of the fill sequence.
    always_comb begin
        // NOTE: every output gets a default before the case so no path through
        // this block leaves a signal unassigned, which would infer a latch.
        state_d   = state_q;
        issuing   = 1'b0;
        receiving = 1'b0;
        mem_en    = 1'b0;
        mem_addr  = '0;
        fill_word = '0;
        fill_data = '0;
        fill_we_i = 1'b0;
        fill_we_d = 1'b0;
        tag_we_i  = 1'b0;
        tag_we_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                issuing   = !iss_q[3];
                receiving = mem_data_valid;
                if (issuing) begin
                    mem_en   = 1'b1;
                    mem_addr = fill_addr_q + {{(ADDR_W-4){1'b0}}, iss_q[2:0], 1'b0};
                end
                if (receiving) begin
                    fill_word = rcv_q;
                    fill_data = mem_data_in;
                    fill_we_i = !grant_d_q;
                    fill_we_d = grant_d_q;
                    if (rcv_q == 3'd7) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                tag_we_i = !grant_d_q;
                tag_we_d = grant_d_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping, latched block base and the issue/receive counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_q          <= '0;
            rcv_q          <= '0;
            last_grant_d_q <= 1'b0;
            grant_d_q      <= 1'b0;
            fill_addr_q    <= '0;
        end else begin
            if (grant) begin
                iss_q          <= '0;
                rcv_q          <= '0;
                grant_d_q      <= grant_sel_d;
                last_grant_d_q <= grant_sel_d;
                fill_addr_q    <= grant_base;
            end else begin
                if (issuing) begin
                    iss_q <= iss_q + 4'd1;
                end
                if (receiving) begin
                    rcv_q <= rcv_q + 3'd1;
                end
            end
        end
    end

    // Status outputs straight from registered state.
    always_comb begin
        fill_addr = fill_addr_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed stimulus with a scoreboard. Each stimulus step
// pushes the reads, word writes and tag write it expects (with the cycle they
// must appear in) into queues; a negedge monitor pops and compares whenever
// the DUT presents a read, a data write or a tag write. A small pipelined
// memory model answers every read MEM_LAT cycles later.
module tb_cache_fill_ctrl;

    localparam int AW      = 16;
    localparam int MEM_LAT = 4;

    logic          clk            = 1'b0;
    logic          rst            = 1'b0;
    logic          i_miss         = 1'b0;
    logic [AW-1:0] i_miss_addr    = '0;
    logic          d_miss         = 1'b0;
    logic [AW-1:0] d_miss_addr    = '0;
    logic          mem_data_valid = 1'b0;
    logic [15:0]   mem_data_in    = '0;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] fill_addr;
    logic [2:0]    fill_word;
    logic [15:0]   fill_data;
    logic          fill_we_i, fill_we_d, tag_we_i, tag_we_d, busy;

    cache_fill_ctrl #(.MEM_LATENCY(MEM_LAT), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data_in    (mem_data_in),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .fill_addr      (fill_addr),
        .fill_word      (fill_word),
        .fill_data      (fill_data),
        .fill_we_i      (fill_we_i),
        .fill_we_d      (fill_we_d),
        .tag_we_i       (tag_we_i),
        .tag_we_d       (tag_we_d),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Cycle k is the interval following the k-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        d;
        logic [2:0]  word;
        logic [15:0] val;
    } exp_t;

    exp_t q_rd[$];
    exp_t q_wr[$];
    exp_t q_tag[$];

    int errors = 0;
    int checks = 0;

    // Memory model state: response slot per cycle (mod 16), plus stray pulses.
    int          resp_cyc [16] = '{default: -1};
    logic [15:0] resp_d   [16] = '{default: '0};
    int          extra_cyc     = -1;
    logic        rand_mode     = 1'b1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0] ^ 8'h5A, a[15:8]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Memory data driver: answers captured reads, plus injected stray pulses.
    always @(posedge clk) begin
        #2;
        mem_data_valid = (resp_cyc[cyc % 16] == cyc) || (extra_cyc == cyc) ||
                         (rand_mode && ($urandom_range(0, 1) == 1));
        mem_data_in    = (resp_cyc[cyc % 16] == cyc) ? resp_d[cyc % 16] : 16'($urandom);
    end

    // Monitor: captures reads for the memory model and scores every output.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("reset_outputs",
                  {7'd0, mem_en, mem_addr, fill_addr, fill_word, fill_data,
                   fill_we_i, fill_we_d, tag_we_i, tag_we_d, busy}, 64'd0);
        end else begin
            if (mem_en) begin
                resp_cyc[(cyc + MEM_LAT) % 16] = cyc + MEM_LAT;
                resp_d[(cyc + MEM_LAT) % 16]   = mem_word(mem_addr);
                if (q_rd.size() == 0) begin
                    check("rd_unexpected", {63'd0, mem_en}, 64'd0);
                end else begin
                    e = q_rd.pop_front();
                    check("rd_addr", mem_addr, e.val);
                    check("rd_cycle", cyc, e.cyc);
                end
            end
            if (fill_we_i || fill_we_d) begin
                check("fill_we_onehot", {63'd0, fill_we_i & fill_we_d}, 64'd0);
                if (q_wr.size() == 0) begin
                    check("wr_unexpected", {fill_we_i, fill_we_d}, 64'd0);
                end else begin
                    e = q_wr.pop_front();
                    check("wr_cache_d", {63'd0, fill_we_d}, {63'd0, e.d});
                    check("wr_word", fill_word, e.word);
                    check("wr_data", fill_data, e.val);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
            if (tag_we_i || tag_we_d) begin
                check("tag_we_onehot", {63'd0, tag_we_i & tag_we_d}, 64'd0);
                if (q_tag.size() == 0) begin
                    check("tag_unexpected", {tag_we_i, tag_we_d}, 64'd0);
                end else begin
                    e = q_tag.pop_front();
                    check("tag_cache_d", {63'd0, tag_we_d}, {63'd0, e.d});
                    check("tag_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next();
    endtask

    // Expected response of one complete fill whose miss is seen in IDLE at c0.
    task automatic expect_fill(input logic d, input logic [15:0] addr, input int c0);
        logic [15:0] base;
        exp_t e;
        base = addr & 16'hFFF0;
        for (int w = 0; w < 8; w++) begin
            e.d    = d;
            e.word = 3'(w);
            e.cyc  = c0 + 1 + w;
            e.val  = base + 16'(2 * w);
            q_rd.push_back(e);
            e.cyc  = c0 + 1 + MEM_LAT + w;
            e.val  = mem_word(base + 16'(2 * w));
            q_wr.push_back(e);
        end
        e.word = 3'd0;
        e.val  = '0;
        e.cyc  = c0 + 9 + MEM_LAT;
        q_tag.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q_rd.size() + q_wr.size() + q_tag.size()) != 0 && n < budget) begin
            next();
            n++;
        end
        check("drain_pending", q_rd.size() + q_wr.size() + q_tag.size(), 64'd0);
    endtask

    initial begin
        int c0;

        // Reset held with random misses, addresses and memory pulses.
        repeat (6) begin
            next();
            i_miss      = 1'($urandom);
            d_miss      = 1'($urandom);
            i_miss_addr = 16'($urandom);
            d_miss_addr = 16'($urandom);
        end
        next();
        i_miss    = 1'b0;
        d_miss    = 1'b0;
        rand_mode = 1'b0;
        rst       = 1'b1;
        repeat (3) next();
        @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_fill_addr", fill_addr, 64'd0);

        // Stray memory pulse in IDLE: no write, state stays IDLE.
        next();
        extra_cyc = cyc;
        @(negedge clk);
        check("idle_stray_busy", {63'd0, busy}, 64'd0);
        check("idle_stray_we", {fill_we_i, fill_we_d}, 64'd0);

        // Single I miss at 1236 with a stray pulse during DONE.
        next();
        c0          = cyc;
        i_miss      = 1'b1;
        i_miss_addr = 16'h1236;
        expect_fill(1'b0, 16'h1236, c0);
        goto(c0 + 1);
        @(negedge clk);
        check("single_busy", {63'd0, busy}, 64'd1);
        check("single_fill_addr", fill_addr, 64'h1230);
        goto(c0 + 13);
        extra_cyc = cyc;
        @(negedge clk);
        check("done_stray_we", {fill_we_i, fill_we_d}, 64'd0);
        goto(c0 + 14);
        i_miss = 1'b0;
        @(negedge clk);
        check("after_done_busy", {63'd0, busy}, 64'd0);
        drain(20);

        // Simultaneous pair: D first, then I; next pair goes to D again.
        next();
        c0          = cyc;
        i_miss      = 1'b1;
        i_miss_addr = 16'h2468;
        d_miss      = 1'b1;
        d_miss_addr = 16'hBEEF;
        expect_fill(1'b1, 16'hBEEF, c0);
        expect_fill(1'b0, 16'h2468, c0 + 14);
        goto(c0 + 1);
        @(negedge clk);
        check("pair1_fill_addr", fill_addr, 64'hBEE0);
        goto(c0 + 14);
        d_miss = 1'b0;
        goto(c0 + 15);
        @(negedge clk);
        check("pair1_second_fill_addr", fill_addr, 64'h2460);
        goto(c0 + 28);
        i_miss_addr = 16'h0F0A;
        d_miss      = 1'b1;
        d_miss_addr = 16'hFFFE;
        expect_fill(1'b1, 16'hFFFE, c0 + 28);
        expect_fill(1'b0, 16'h0F0A, c0 + 42);
        goto(c0 + 42);
        d_miss = 1'b0;
        goto(c0 + 56);
        i_miss = 1'b0;
        drain(20);

        // I miss drops (and its address changes) at FILL cycle 3.
        next();
        c0          = cyc;
        i_miss      = 1'b1;
        i_miss_addr = 16'h7A5C;
        expect_fill(1'b0, 16'h7A5C, c0);
        goto(c0 + 3);
        i_miss      = 1'b0;
        i_miss_addr = 16'h0000;
        drain(30);

        // Reset at cycle 7 of a D fill; stragglers afterwards are ignored.
        next();
        c0          = cyc;
        d_miss      = 1'b1;
        d_miss_addr = 16'h4AB8;
        expect_fill(1'b1, 16'h4AB8, c0);
        goto(c0 + 7);
        rst    = 1'b0;
        d_miss = 1'b0;
        q_rd.delete();
        q_wr.delete();
        q_tag.delete();
        @(negedge clk);
        check("midreset_busy", {63'd0, busy}, 64'd0);
        goto(c0 + 8);
        rst = 1'b1;
        for (int k = 8; k <= 10; k++) begin
            goto(c0 + k);
            @(negedge clk);
            check("straggler_valid", {63'd0, mem_data_valid}, 64'd1);
            check("straggler_we", {fill_we_i, fill_we_d}, 64'd0);
        end
        goto(c0 + 14);
        @(negedge clk);
        check("final_busy", {63'd0, busy}, 64'd0);
        drain(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
